seg7_reader: RTL and testbench

- Reverse direction of the team's 7-segment digit driver: samples a 7-segment pattern bus (s0..s6) and recovers the 4-bit hex symbol it displays.
- Synchronises the bus, requires the pattern to be stable for a programmable number of cycles, then matches it against the 16-entry hex glyph table.
- Delivers each recovered symbol once through a single-entry valid/ready output buffer.
- Used to read back and check display drivers, and to accept symbols from external segment buses.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_glyph_match.sv | 26 ++
 rtl/seg7_reader.sv | 160 ++++++++++++++++
 tb/tb_seg7_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the hex glyph table for the 7-segment reader.
// Segment bit order: bit0 = a (s0) ... bit6 = g (s6), active-high.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] hex_t;

    typedef enum logic {
        WAIT = 1'b0,
        FIRE = 1'b1
    } rd_state_t;

    // All segments off: a valid "nothing displayed" state, never an error.
    localparam seg_t SEG_BLANK = 7'h00;

    // Saturation ceiling of the stability counter.
    localparam logic [3:0] CNT_MAX = 4'd15;

    // Index = hex value, entry = segment pattern (g..a).
    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_glyph_match.sv
// seg7_glyph_match: combinational lookup of a segment pattern in the hex
// glyph table. If several entries matched, the lowest index would win.
// Ports:
//   seg_i   pattern to look up
//   hit_o   pattern is one of the 16 glyphs
//   code_o  hex value of the matching glyph (0 when no hit)
module seg7_glyph_match
    import seg7_pkg::*;
(
    input  seg_t seg_i,
    output logic hit_o,
    output hex_t code_o
);

    always_comb begin
        hit_o  = 1'b0;
        code_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (!hit_o && (seg_i == SEG_GLYPH[i])) begin
                hit_o  = 1'b1;
                code_o = hex_t'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex symbols from a 7-segment pattern bus.
// The bus is synchronised, must hold the same pattern for STABLE_CYCLES
// samples, and is then decoded once; the result goes out through a
// single-entry valid/ready buffer.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   seg_in       raw segment bus (bit0 = a ... bit6 = g)
//   sample_en    when low, stability tracking freezes and nothing decodes
//   out_code     decoded symbol, qualified by out_valid
//   out_valid    held until out_ready is seen high on a rising edge
//   out_ready    consumer accept
//   err_pulse    one-cycle flag: stable, non-blank pattern with no glyph
//   overflow     sticky: a decoded symbol was dropped (buffer full)
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       sample_en,
    output logic [3:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_pulse,
    output logic       overflow
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    seg_t      sync_q [SYNC_STAGES];
    seg_t      seg_s;
    seg_t      prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic      reported_q, reported_d;
    rd_state_t state_q, state_d;
    seg_t      fire_pat_q, fire_pat_d;
    hex_t      code_q, code_d;
    logic      valid_q, valid_d;
    logic      err_q, err_d;
    logic      ovf_q, ovf_d;
    logic      fire_now;
    logic      match_hit;
    hex_t      match_code;

    // Synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign seg_s = sync_q[SYNC_STAGES-1];

    // Decode fires once per stable run, only on an enabled sample.
    assign fire_now = (state_q == WAIT) && sample_en &&
                      (cnt_q == STABLE_CNT) && !reported_q;

    // Stability tracking. The pattern is captured into fire_pat at the
    // decision edge so a change landing on that same edge cannot alter
    // what gets decoded; such a change still clears reported.
    always_comb begin
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        reported_d = reported_q;
        fire_pat_d = fire_pat_q;
        if (fire_now) begin
            fire_pat_d = prev_q;
            reported_d = 1'b1;
        end
        if (sample_en) begin
            if (seg_s != prev_q) begin
                prev_d     = seg_s;
                cnt_d      = 4'd1;
                reported_d = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (fire_now) state_d = FIRE;
            FIRE:    state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    seg7_glyph_match u_match (
        .seg_i  (fire_pat_q),
        .hit_o  (match_hit),
        .code_o (match_code)
    );

    // Output buffer. An accept and a load on the same edge leave the new
    // symbol visible with valid still high.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if ((state_q == FIRE) && (fire_pat_q != SEG_BLANK)) begin
            if (match_hit) begin
                if (!valid_q || out_ready) begin
                    valid_d = 1'b1;
                    code_d  = match_code;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            cnt_q      <= '0;
            reported_q <= 1'b0;
            state_q    <= WAIT;
            fire_pat_q <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            reported_q <= reported_d;
            state_q    <= state_d;
            fire_pat_q <= fire_pat_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_code  = code_q;
    assign out_valid = valid_q;
    assign err_pulse = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed checks of seg7_reader with STABLE_CYCLES = 4.
// Inputs change on the falling edge; the first rising edge that samples a
// new value is edge 0, so a symbol shows out_valid from edge 7 onwards.
module tb_seg7_reader;

    localparam int LAT = 7;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       sample_en;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       err_pulse;
    logic       overflow;

    int total;
    int bad;

    // Watch-window results.
    int         w_edge;
    int         w_valid;
    int         w_err;
    int         w_first_v;
    int         w_first_e;
    int         w_code9;
    logic [3:0] w_code;

    logic [6:0] glyph [16];

    seg7_reader #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .sample_en (sample_en),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_pulse (err_pulse),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic watch_reset();
        w_edge    = 0;
        w_valid   = 0;
        w_err     = 0;
        w_first_v = -1;
        w_first_e = -1;
        w_code9   = 0;
        w_code    = '0;
    endtask

    // Runs n cycles, recording outputs after each rising edge.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                w_valid++;
                w_code = out_code;
                if (out_code == 4'h9) w_code9++;
                if (w_first_v < 0) w_first_v = w_edge;
            end
            if (err_pulse) begin
                w_err++;
                if (w_first_e < 0) w_first_e = w_edge;
            end
            w_edge++;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        rst_n     = 1'b0;
        seg_in    = 7'h00;
        sample_en = 1'b1;
        out_ready = 1'b1;
        cycles(3);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        cycles(10);

        // Single symbol: latency, value, no repeat while held.
        watch_reset();
        seg_in = 7'h5B;
        watch(57);
        chk("t1_latency", 32'(w_first_v), 32'(LAT));
        chk("t1_count", 32'(w_valid), 32'd1);
        chk("t1_code", 32'(w_code), 32'h2);
        chk("t1_err", 32'(w_err), 32'd0);
        seg_in = 7'h00;
        cycles(10);

        // Sweep all glyphs with blank in between.
        for (int g = 0; g < 16; g++) begin
            watch_reset();
            seg_in = glyph[g];
            watch(10);
            seg_in = 7'h00;
            watch(10);
            chk($sformatf("sweep%0d_count", g), 32'(w_valid), 32'd1);
            chk($sformatf("sweep%0d_code", g), 32'(w_code), 32'(g));
            chk($sformatf("sweep%0d_err", g), 32'(w_err), 32'd0);
        end

        // Short glitch inside a run: only the final stable 7F decodes.
        watch_reset();
        seg_in = 7'h7F;
        watch(2);
        seg_in = 7'h6F;
        watch(2);
        seg_in = 7'h7F;
        watch(20);
        chk("glitch_count", 32'(w_valid), 32'd1);
        chk("glitch_code", 32'(w_code), 32'h8);
        chk("glitch_no9", 32'(w_code9), 32'd0);
        seg_in = 7'h00;
        cycles(10);

        // Invalid pattern: one error pulse, no output.
        watch_reset();
        seg_in = 7'h49;
        watch(20);
        chk("bad_err_count", 32'(w_err), 32'd1);
        chk("bad_err_latency", 32'(w_first_e), 32'(LAT));
        chk("bad_valid", 32'(w_valid), 32'd0);
        seg_in = 7'h00;
        cycles(10);

        // Back-pressure: second symbol dropped, first one held.
        out_ready = 1'b0;
        seg_in = 7'h4F;
        cycles(10);
        seg_in = 7'h00;
        cycles(10);
        chk("bp_ovf_before", 32'(overflow), 32'd0);
        seg_in = 7'h07;
        cycles(10);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_code", 32'(out_code), 32'h3);
        chk("bp_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        cycles(1);
        chk("bp_accept", 32'(out_valid), 32'd0);
        seg_in = 7'h00;
        cycles(10);
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Reset while a symbol is pending; the held pattern comes back.
        out_ready = 1'b0;
        seg_in = 7'h66;
        cycles(10);
        chk("rr_pending", 32'(out_valid), 32'd1);
        chk("rr_pending_code", 32'(out_code), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("rr_valid0", 32'(out_valid), 32'd0);
        chk("rr_code0", 32'(out_code), 32'd0);
        chk("rr_ovf0", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        watch_reset();
        watch(20);
        chk("rr_latency", 32'(w_first_v), 32'(LAT));
        chk("rr_count", 32'(w_valid), 32'd1);
        chk("rr_code", 32'(w_code), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
